// File: rtl/md_sched_if.sv
// md_sched_if: E-stage operand, flush and D-stage use inputs plus HI/LO, Busy and stall outputs
interface md_sched_if;
  logic req;
  logic [2:0] MDOp_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic MDUse_D;
  logic Busy;
  logic Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output req, MDOp_E, A_E, B_E, MDUse_D, input Busy, Stall_MD, HI, LO);
  modport slave (input req, MDOp_E, A_E, B_E, MDUse_D, output Busy, Stall_MD, HI, LO);
endinterface

// File: rtl/md_sched.sv
// md_sched: fixed-latency mult/div sequencer that owns HI/LO and drives the MD stall request
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_sched_if.slave md
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [3:0] cnt;
  logic busy, pend_dz;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic is_mul, is_div, start, dz, ovf;
  logic [31:0] a, b, db, res_hi, res_lo;
  logic signed [31:0] sq, sr;
  logic [63:0] sprod, uprod;
  assign a = md.A_E;
  assign b = md.B_E;
  assign is_mul = md.MDOp_E == 3'd1 || md.MDOp_E == 3'd2;
  assign is_div = md.MDOp_E == 3'd3 || md.MDOp_E == 3'd4;
  assign start = (is_mul || is_div) && !md.req && !busy;
  assign dz = b == 32'd0;
  assign ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  // dividing by 1 instead yields the defined overflow result and keeps /0 out of the datapath
  assign db = (dz || ovf) ? 32'd1 : b;
  assign sq = $signed(a) / $signed(db);
  assign sr = $signed(a) % $signed(db);
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};
  assign res_lo = md.MDOp_E == 3'd1 ? sprod[31:0] : md.MDOp_E == 3'd2 ? uprod[31:0] : md.MDOp_E == 3'd3 ? sq : a / db;
  assign res_hi = md.MDOp_E == 3'd1 ? sprod[63:32] : md.MDOp_E == 3'd2 ? uprod[63:32] : md.MDOp_E == 3'd3 ? sr : a % db;
  assign md.Stall_MD = md.MDUse_D && (busy || is_mul || is_div);
  assign md.Busy = busy;
  assign md.HI = hi;
  assign md.LO = lo;
  // start/count/commit sequencing plus mthi/mtlo writes when idle and not flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        busy <= 1'b1;
        cnt <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_dz <= is_div && dz;
      end else if (!md.req && md.MDOp_E == 3'd5) hi <= a;
      else if (!md.req && md.MDOp_E == 3'd6) lo <= a;
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state <= IDLE;
        busy <= 1'b0;
        if (!pend_dz) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed HI/LO scheduler vectors checked by a commit-triggered scoreboard
module tb_md_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  md_sched_if bus();
  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus));
  typedef struct {string nm; logic [31:0] hi; logic [31:0] lo; int n;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  logic busy_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every Busy fall pops one expected result and busy length
  always @(negedge clk) begin
    exp_t e;
    if (bus.Busy === 1'b1) busy_cnt++;
    else if (busy_q) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit: HI %h LO %h with empty queue", bus.HI, bus.LO);
      end else begin
        e = q.pop_front();
        chk({e.nm, "_hi"}, bus.HI, e.hi);
        chk({e.nm, "_lo"}, bus.LO, e.lo);
        chk({e.nm, "_busy_cycles"}, 32'(busy_cnt), 32'(e.n));
      end
      busy_cnt = 0;
    end
    busy_q = bus.Busy;
  end

  // an op presented while Busy must not disturb HI/LO before the commit edge
  assert property (@(posedge clk) disable iff (reset)
    (bus.Busy && bus.MDOp_E inside {[3'd1:3'd6]}) |=> (!bus.Busy || ($stable(bus.HI) && $stable(bus.LO))))
    else begin
      failures++;
      $display("FAIL busy_op_ignored: HI/LO changed while Busy");
    end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string nm, input logic [31:0] eh, input logic [31:0] el, input int n);
    if (n > 0) q.push_back('{nm, eh, el, n});
    bus.MDOp_E = op;
    bus.A_E = a;
    bus.B_E = b;
    @(posedge clk);
    #1 bus.MDOp_E = 3'd0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Busy === 1'b0) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout: Busy still %b after 20 cycles, required 0", nm, bus.Busy);
  endtask

  initial begin
    int sc;
    reset = 1'b1;
    bus.req = 1'b0;
    bus.MDOp_E = 3'd0;
    bus.A_E = '0;
    bus.B_E = '0;
    bus.MDUse_D = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_stall", 32'(bus.Stall_MD), 32'd0);
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, "mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_idle("mult");
    issue(3'd4, 32'd100, 32'd7, "divu", 32'd2, 32'd14, 10);
    wait_idle("divu");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle("div_neg");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'd0, 32'h8000_0000, 10);
    wait_idle("div_ovf");
    issue(3'd5, 32'h11, 32'd0, "mthi", 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("mthi", bus.HI, 32'h11);
    issue(3'd6, 32'h22, 32'd0, "mtlo", 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("mtlo", bus.LO, 32'h22);
    chk("mtlo_hi_kept", bus.HI, 32'h11);
    issue(3'd3, 32'd5, 32'd0, "div0", 32'h11, 32'h22, 10);
    wait_idle("div0");
    bus.req = 1'b1;
    issue(3'd1, 32'd3, 32'd3, "req_mult", 32'd0, 32'd0, 0);
    bus.req = 1'b0;
    @(negedge clk);
    chk("req_busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    chk("req_busy_later", 32'(bus.Busy), 32'd0);
    chk("req_hi", bus.HI, 32'h11);
    chk("req_lo", bus.LO, 32'h22);
    issue(3'd1, 32'd7, 32'd6, "mult_req_run", 32'd0, 32'h2A, 5);
    @(posedge clk);
    #1 bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_idle("mult_req_run");
    q.push_back('{"stall_multu", 32'd1, 32'hFFFF_FFFE, 5});
    bus.MDUse_D = 1'b1;
    bus.MDOp_E = 3'd2;
    bus.A_E = 32'hFFFF_FFFF;
    bus.B_E = 32'd2;
    #1 chk("stall_start", 32'(bus.Stall_MD), 32'd1);
    @(posedge clk);
    #1 bus.MDOp_E = 3'd6;
    bus.A_E = 32'hDEAD;
    sc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.Stall_MD) sc++;
      if (i == 1) begin
        chk("mtlo_busy_ignored", bus.LO, 32'h2A);
        bus.MDOp_E = 3'd0;
      end
    end
    chk("stall_cycles", 32'(sc), 32'd5);
    chk("stall_after", 32'(bus.Stall_MD), 32'd0);
    bus.MDUse_D = 1'b0;
    wait_idle("stall_multu");
    issue(3'd4, 32'd100, 32'd7, "reset_div", 32'd0, 32'd0, 3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
    chk("rst_mid_hi", bus.HI, 32'd0);
    chk("rst_mid_lo", bus.LO, 32'd0);
    repeat (14) @(negedge clk);
    chk("rst_no_late_hi", bus.HI, 32'd0);
    chk("rst_no_late_lo", bus.LO, 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
